// File: rtl/rotate_right_seq.sv
// rotate_right_seq: iterative rotate-right unit with a start/busy/done handshake.
// Define ROT_FAST2_EN to rotate two positions per cycle while at least two remain.
module rotate_right_seq #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] shreg_q, shreg_d, dout_q;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;
`ifdef ROT_FAST2_EN
    logic two;
    assign two     = cnt_q >= AMT_W'(2);
    assign shreg_d = two ? {shreg_q[1:0], shreg_q[WIDTH-1:2]} : {shreg_q[0], shreg_q[WIDTH-1:1]};
    assign cnt_d   = cnt_q - (two ? AMT_W'(2) : AMT_W'(1));
`else
    assign shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
    assign cnt_d   = cnt_q - AMT_W'(1);
`endif
    // IDLE and DONE share the accept path, so a start in DONE costs no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else if (state_q == ROT) begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            if (cnt_d == '0) begin
                dout_q  <= shreg_d;
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
            if (start) begin
                shreg_q <= data_in;
                cnt_q   <= amt;
                if (amt != '0) begin
                    state_q <= ROT;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    dout_q  <= data_in;
                end
            end else begin
                state_q <= IDLE;
            end
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = dout_q;
endmodule

// File: tb/tb_rotate_right_seq.sv
// tb_rotate_right_seq: directed and random checks of rotate_right_seq against a reference rotate.
module tb_rotate_right_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  amt = '0;
    logic        busy, done;
    logic [15:0] data_out;
    int total = 0;
    int bad = 0;

    rotate_right_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .amt(amt),
        .busy(busy), .done(done), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ror_ref(input logic [15:0] d, input logic [3:0] a);
        logic [31:0] x;
        x = {d, d} >> a;
        return x[15:0];
    endfunction

    function automatic int lat_ref(input logic [3:0] a);
`ifdef ROT_FAST2_EN
        return (int'(a) + 1) / 2 + 1;
`else
        return int'(a) + 1;
`endif
    endfunction

    // Starts one op and returns in its done cycle; inj>0 pulses an ignored start at that cycle.
    task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] a, input int inj);
        logic [15:0] prev;
        int lat, nbusy;
        prev = data_out;
        data_in = d;
        amt = a;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) begin
                nbusy++;
                chk({tag, "_stable"}, data_out, prev);
            end
            if (lat == inj) begin
                data_in = 16'hFFFF;
                amt = 4'd3;
                start = 1'b1;
            end
            step();
            start = 1'b0;
            lat++;
        end
        chk({tag, "_lat"}, lat, lat_ref(a));
        chk({tag, "_busycyc"}, nbusy, lat_ref(a) - 1);
        chk({tag, "_data"}, data_out, ror_ref(d, a));
        chk({tag, "_busy_in_done"}, busy, 1'b0);
    endtask

    task automatic idle_check(input string tag);
        step();
        chk({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int ndone;
        logic [15:0] rd;
        logic [3:0] ra;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_data", data_out, 16'h0000);
        rst_n = 1'b1;
        step();
        chk("idle_done", done, 1'b0);

        run_op("r8001_1", 16'h8001, 4'd1, 0);
        chk("r8001_val", data_out, 16'hC000);
        idle_check("r8001");

        run_op("r1234_4", 16'h1234, 4'd4, 0);
        chk("r1234_val", data_out, 16'h4123);
        run_op("b2b_abcd_0", 16'hABCD, 4'd0, 0);
        chk("b2b_val", data_out, 16'hABCD);
        idle_check("b2b");

        run_op("r8000_15", 16'h8000, 4'd15, 5);
        chk("r8000_val", data_out, 16'h0001);
        idle_check("r8000");

        run_op("zero_7", 16'h0000, 4'd7, 0);
        idle_check("zero");
        run_op("ones_9", 16'hFFFF, 4'd9, 0);
        chk("ones_val", data_out, 16'hFFFF);
        idle_check("ones");
        run_op("rol1", 16'h0001, 4'd15, 0);
        chk("rol1_val", data_out, 16'h0002);
        idle_check("rol1");

        data_in = 16'h1234;
        amt = 4'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("mid_busy_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_data", data_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (done || busy) ndone++;
        end
        chk("arst_no_done", ndone, 0);

        for (int i = 0; i < 500; i++) begin
            rd = 16'($urandom);
            ra = 4'($urandom_range(0, 15));
            run_op("rand", rd, ra, 0);
            if ($urandom_range(0, 1) == 0) idle_check("rand");
        end
        idle_check("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
